// File: rtl/apb_requester_if.sv
// Bus bundle between the processor side, the APB requester and the APB responder.
// The master modport is the requester's view. The slave modport is the view of
// the surrounding processor/responder environment.
interface apb_requester_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);

  // Processor-side request
  logic              proc_sel;
  logic              proc_write;
  logic [ADDR_W-1:0] proc_addr;
  logic [DATA_W-1:0] proc_wdata;
  logic [7:0]        proc_wait_cycles;

  // Processor-side response
  logic              proc_busy;
  logic              proc_done;
  logic              proc_err;
  logic [DATA_W-1:0] proc_rdata;

  // APB request toward the responder
  logic              apb_sel;
  logic              apb_enable;
  logic              apb_write;
  logic [ADDR_W-1:0] apb_addr;
  logic [DATA_W-1:0] apb_wdata;
  logic [7:0]        apb_wait_cycles;

  // APB response from the responder
  logic              apb_ready;
  logic [DATA_W-1:0] apb_rdata;

  modport master (
    input  proc_sel, proc_write, proc_addr, proc_wdata, proc_wait_cycles,
    output proc_busy, proc_done, proc_err, proc_rdata,
    output apb_sel, apb_enable, apb_write, apb_addr, apb_wdata, apb_wait_cycles,
    input  apb_ready, apb_rdata
  );

  modport slave (
    output proc_sel, proc_write, proc_addr, proc_wdata, proc_wait_cycles,
    input  proc_busy, proc_done, proc_err, proc_rdata,
    input  apb_sel, apb_enable, apb_write, apb_addr, apb_wdata, apb_wait_cycles,
    output apb_ready, apb_rdata
  );

endinterface

// File: rtl/apb_requester.sv
// APB requester (initiator).
// A processor request is taken in IDLE and run through one SETUP cycle and
// then ACCESS cycles until the responder raises apb_ready. If the responder
// stalls for TIMEOUT ACCESS cycles, the transfer is abandoned and reported
// with proc_err. Every output comes straight from a flop.
module apb_requester #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  apb_requester_if.master  bus
);

  // The counter must be able to hold TIMEOUT. When the timeout is disabled it
  // keeps one bit so that the logic stays well-formed.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // The counter value at which a still-stalled ACCESS is abandoned. The counter
  // is zero in the first ACCESS cycle, so this fires on the TIMEOUT-th stall.
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t            state_q,  state_d;
  logic              sel_q,    sel_d;
  logic              enable_q, enable_d;
  logic              write_q,  write_d;
  logic [ADDR_W-1:0] addr_q,   addr_d;
  logic [DATA_W-1:0] wdata_q,  wdata_d;
  logic [7:0]        wait_q,   wait_d;
  logic              busy_q,   busy_d;
  logic              done_q,   done_d;
  logic              err_q,    err_d;
  logic [DATA_W-1:0] rdata_q,  rdata_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;

  // Stall counter advance. It saturates instead of wrapping, which matters
  // only when the timeout is disabled.
  logic [CNT_W-1:0] cnt_inc;
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  // Next-state and registered-output computation for all three phases.
  always_comb begin
    // NOTE: every signal gets a default before the case so that no path
    // leaves a signal unassigned. An unassigned path would infer a latch.
    state_d  = state_q;
    sel_d    = sel_q;
    enable_d = enable_q;
    write_d  = write_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wait_d   = wait_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        sel_d    = 1'b0;
        enable_d = 1'b0;
        busy_d   = 1'b0;
        if (bus.proc_sel) begin
          // Take a snapshot of the request. From here on, changes on the
          // processor inputs are ignored until the transfer finishes.
          write_d  = bus.proc_write;
          addr_d   = bus.proc_addr;
          wdata_d  = bus.proc_wdata;
          wait_d   = bus.proc_wait_cycles;
          sel_d    = 1'b1;
          busy_d   = 1'b1;
          state_d  = S_SETUP;
        end
      end

      S_SETUP: begin
        // SETUP lasts one cycle. The responder cannot complete here, so
        // apb_ready is not examined.
        enable_d = 1'b1;
        cnt_d    = '0;
        state_d  = S_ACCESS;
      end

      S_ACCESS: begin
        if (bus.apb_ready) begin
          // Completion wins over a timeout that would fire on the same edge.
          if (!write_q) begin
            rdata_d = bus.apb_rdata;
          end
          done_d   = 1'b1;
          sel_d    = 1'b0;
          enable_d = 1'b0;
          busy_d   = 1'b0;
          state_d  = S_IDLE;
        end else begin
          cnt_d = cnt_inc;
          if ((TIMEOUT > 0) && (cnt_q == CNT_LAST)) begin
            // Abandon the access. proc_rdata keeps its previous value.
            done_d   = 1'b1;
            err_d    = 1'b1;
            sel_d    = 1'b0;
            enable_d = 1'b0;
            busy_d   = 1'b0;
            state_d  = S_IDLE;
          end
        end
      end

      default: begin
        sel_d    = 1'b0;
        enable_d = 1'b0;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end
    endcase
  end

  // State and output registers. An asynchronous reset drops the bus at once,
  // and no completion is reported for the aborted transfer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      sel_q    <= 1'b0;
      enable_q <= 1'b0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wait_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      cnt_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments let every register update from the
      // pre-edge values, independent of statement order.
      state_q  <= state_d;
      sel_q    <= sel_d;
      enable_q <= enable_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wait_q   <= wait_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.apb_sel         = sel_q;
  assign bus.apb_enable      = enable_q;
  assign bus.apb_write       = write_q;
  assign bus.apb_addr        = addr_q;
  assign bus.apb_wdata       = wdata_q;
  assign bus.apb_wait_cycles = wait_q;
  assign bus.proc_busy       = busy_q;
  assign bus.proc_done       = done_q;
  assign bus.proc_err        = err_q;
  assign bus.proc_rdata      = rdata_q;

endmodule
